alu_issue_decoder: RTL
======================

Name: alu_issue_decoder

Overview:
Decode/issue stage that drives the ALU's operand and op_code interface (a, b, op_code).
- Accepts one fetched 32-bit RV32I instruction per handshake.
- Reads register-file operands and decodes OP, OP-IMM, LUI and AUIPC into an ALU op_code plus 32-bit operands.
- Presents the result to the execute stage through a registered valid/ready pipeline slot; a downstream stall holds the slot stable.

Parameters:
XLEN, 32, datapath width of operands and PC
RESET_PC_TAG, 0, value driven on out_pc while the slot is empty

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  upstream instruction valid
in_ready  output  1  decoder can accept this cycle
in_instr  input  32  instruction word
in_pc  input  XLEN  PC of in_instr
rs1_addr  output  5  combinational in_instr[19:15] to register file
rs2_addr  output  5  combinational in_instr[24:20] to register file
rs1_data  input  XLEN  register-file read data, same cycle as rs1_addr
rs2_data  input  XLEN  register-file read data, same cycle as rs2_addr
out_valid  output  1  slot holds a decoded instruction
out_ready  input  1  execute stage accepts
out_a  output  XLEN  ALU operand a
out_b  output  XLEN  ALU operand b
out_op_code  output  4  ALU op_code
out_rd  output  5  destination register
out_we  output  1  write-back enable
out_illegal  output  1  instruction not decodable by this stage
out_pc  output  XLEN  PC of slot instruction

Behaviour:
Reset (async, rst_n low):
- out_valid=0, out_a=0, out_b=0, out_op_code=ALU_NOP, out_rd=0, out_we=0, out_illegal=0, out_pc=RESET_PC_TAG.
- A reset mid-stall discards the slot.

Handshake:
- in_ready = !out_valid || out_ready, combinational.
- Accept when in_valid && in_ready; all out_* load on that edge.
- Latency: 1 cycle from accept to out_valid.
- If out_valid && out_ready && !in_valid, out_valid clears next cycle.
- Simultaneous drain and accept: slot reloads, out_valid stays 1 with no bubble.
- While out_valid && !out_ready, all out_* hold bit-stable.

Decode (opcode = in_instr[6:0]):
- 0110011 OP: a=rs1_data, b=rs2_data, we=1.
  - funct3 000: funct7 0000000 -> ALU_ADD; 0100000 -> ALU_SUB.
  - 001 -> ALU_SSL; 100 -> ALU_XOR; 110 -> ALU_OR; 111 -> ALU_AND; 010 -> ALU_SLT; 011 -> ALU_SLTU.
  - 101: funct7 0000000 -> ALU_SRL; 0100000 -> ALU_SRA.
  - Any other funct7 -> illegal.
- 0010011 OP-IMM: a=rs1_data, b=sign-extended instr[31:20], same funct3 map; no SUB.
  - Shifts use funct7 as for OP; for 101, instr[30] selects SRA.
  - Shift with instr[25]=1 -> illegal.
- 0110111 LUI: a=0, b={instr[31:12],12'b0}, ALU_ADD, we=1.
- 0010111 AUIPC: a=in_pc, b={instr[31:12],12'b0}, ALU_ADD, we=1.
- Any other opcode, or illegal encoding: out_op_code=ALU_NOP, out_we=0, out_illegal=1, a=b=0.
- Shift ops: out_b = {27'b0, b[4:0]} (masked before issue).
- rd=x0: out_we forced 0; op_code is unchanged.

Optional Feature:
ALU_DEC_FLUSH_EN: adds input flush (1 bit).
- With the macro, flush=1 on a clock edge clears out_valid and blocks acceptance: in_ready=0 while flush=1, so no instruction is accepted or lost that cycle.
- Without the macro, the port and its logic are absent.

Decomposition:
- Shared package parameters.vh holds the ALU op_code constants:
  - ALU_ADD=0, ALU_SUB=1, ALU_XOR=2, ALU_OR=3, ALU_AND=4, ALU_SSL=5, ALU_SRL=6, ALU_SRA=7, ALU_SLT=8, ALU_SLTU=9, ALU_NOP=10.
  - Also the opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
- One combinational sub-module, rv32_alu_decode (instr, pc, rs1/rs2 data -> a, b, op_code, we, illegal), with the pipeline slot in the top.

Test Plan:
- Reset: rst_n low mid-cycle -> outputs drop immediately to reset values; out_op_code=10, in_ready=1.
- ADD x3,x1,x2 with rs1=5, rs2=7 -> next cycle out_valid=1, out_a=5, out_b=7, out_op_code=0, out_rd=3, out_we=1.
- SRAI x4,x1,3 (0x4030D213), rs1=0x80000000 -> out_op_code=7, out_b=3; ADDI imm=0xFFF -> out_b=0xFFFFFFFF.
- Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next instruction loads with no bubble.
- Illegal: opcode 0000011 -> out_illegal=1, out_we=0, out_op_code=10; AUIPC x1,0x1 at pc 0x100 -> a=0x100, b=0x1000, op=0.
- rd=x0: ADD x0,x1,x2 -> out_we=0; with ALU_DEC_FLUSH_EN, flush on a stalled slot -> out_valid=0 next cycle.

Source files
------------

// File: rtl/alu_issue_decoder_pkg.sv
// Shared ALU op_code / RV32I opcode constants and small decode helpers.
// Latency: n/a (constants and pure functions). Backpressure: n/a.
package alu_issue_decoder_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_XOR  = 4'd2;
    localparam alu_op_t ALU_OR   = 4'd3;
    localparam alu_op_t ALU_AND  = 4'd4;
    localparam alu_op_t ALU_SSL  = 4'd5;
    localparam alu_op_t ALU_SRL  = 4'd6;
    localparam alu_op_t ALU_SRA  = 4'd7;
    localparam alu_op_t ALU_SLT  = 4'd8;
    localparam alu_op_t ALU_SLTU = 4'd9;
    localparam alu_op_t ALU_NOP  = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 -> op for the encodings that need no funct7 disambiguation
    function automatic alu_op_t funct3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SSL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic is_shift(input alu_op_t op);
        return (op == ALU_SSL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/rv32_alu_decode.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode into ALU op_code and operands.
// Latency: purely combinational. Backpressure: none (no state).
module rv32_alu_decode
    import alu_issue_decoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_dat,
    input  logic [XLEN-1:0] i_rs2_dat,
    output logic [XLEN-1:0] o_a,
    output logic [XLEN-1:0] o_b,
    output alu_op_t         o_op_code,
    output logic            o_we,
    output logic            o_illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    alu_op_t         w_op;
    logic            w_legal;

    assign w_opcode = i_instr[6:0];
    assign w_rd     = i_instr[11:7];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign w_imm_i  = XLEN'($signed(i_instr[31:20]));
    assign w_imm_u  = XLEN'($signed({i_instr[31:12], 12'b0}));

    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_op    = ALU_NOP;
        w_legal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_a     = i_rs1_dat;
                w_b     = i_rs2_dat;
                w_op    = funct3_op(w_f3);
                w_legal = (w_f7 == F7_BASE);
                if (w_f3 == 3'b000 && w_f7 == F7_ALT) begin
                    w_op    = ALU_SUB;
                    w_legal = 1'b1;
                end else if (w_f3 == 3'b101 && w_f7 == F7_ALT) begin
                    w_op    = ALU_SRA;
                    w_legal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                w_a     = i_rs1_dat;
                w_b     = w_imm_i;
                w_op    = funct3_op(w_f3);
                w_legal = 1'b1;
                // Only shifts carry a funct7 field; other immediates use all 12 bits
                if (w_f3 == 3'b001) begin
                    w_legal = (w_f7 == F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                    if (w_f7 == F7_ALT) w_op = ALU_SRA;
                end
            end
            OPC_LUI: begin
                w_b     = w_imm_u;
                w_op    = ALU_ADD;
                w_legal = 1'b1;
            end
            OPC_AUIPC: begin
                w_a     = i_pc;
                w_b     = w_imm_u;
                w_op    = ALU_ADD;
                w_legal = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_a       = '0;
        o_b       = '0;
        o_op_code = ALU_NOP;
        o_we      = 1'b0;
        o_illegal = 1'b1;
        if (w_legal) begin
            o_a       = w_a;
            o_b       = is_shift(w_op) ? {{(XLEN-5){1'b0}}, w_b[4:0]} : w_b;
            o_op_code = w_op;
            o_we      = (w_rd != 5'd0);
            o_illegal = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_decoder.sv
// Decode/issue stage feeding the ALU through one registered valid/ready slot; optional flush via ALU_DEC_FLUSH_EN.
// Latency: 1 cycle accept->out_valid. Backpressure: in_ready=!out_valid||out_ready, slot holds bit-stable while stalled.
module alu_issue_decoder
    import alu_issue_decoder_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef ALU_DEC_FLUSH_EN
    input  logic            flush,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_op_code,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    logic            w_flush;
    logic            w_accept;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    alu_op_t         w_op;
    logic            w_we;
    logic            w_illegal;

    logic            r_valid;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    alu_op_t         r_op;
    logic [4:0]      r_rd;
    logic            r_we;
    logic            r_illegal;
    logic [XLEN-1:0] r_pc;

`ifdef ALU_DEC_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign in_ready = !w_flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    rv32_alu_decode #(.XLEN(XLEN)) u_dec (
        .i_instr   (in_instr),
        .i_pc      (in_pc),
        .i_rs1_dat (rs1_data),
        .i_rs2_dat (rs2_data),
        .o_a       (w_a),
        .o_b       (w_b),
        .o_op_code (w_op),
        .o_we      (w_we),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= ALU_NOP;
            r_rd      <= '0;
            r_we      <= 1'b0;
            r_illegal <= 1'b0;
            r_pc      <= RESET_PC_TAG;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_a       <= w_a;
            r_b       <= w_b;
            r_op      <= w_op;
            r_rd      <= in_instr[11:7];
            r_we      <= w_we;
            r_illegal <= w_illegal;
            r_pc      <= in_pc;
        end else if (out_ready || w_flush) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_a       = r_a;
    assign out_b       = r_b;
    assign out_op_code = r_op;
    assign out_rd      = r_rd;
    assign out_we      = r_we;
    assign out_illegal = r_illegal;
    assign out_pc      = r_valid ? r_pc : RESET_PC_TAG;

endmodule
